btn_debounce: RTL and testbench

Button conditioning stage that sits between the board push-button pins and the CPU I/O bus. It synchronises each raw button to `clk`, filters contact bounce with a per-button stability counter and presents the filtered levels. It also produces one-cycle press pulses and CPU-clearable sticky press flags, which the bus multiplexer exposes as the BTN field.

---
 rtl/btn_debounce.sv | 110 +++++++++++
 tb/tb_btn_debounce.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: push-button conditioning between the board pins and the CPU bus.
// Each button has its own channel: a two-flop synchroniser, a stability counter
// that accepts a new level only after DB_LIMIT consecutive differing samples,
// a one-cycle press pulse on accepted 0->1 transitions, and a sticky
// "pressed since last clear" flag that the CPU clears through a masked strobe.
// All outputs come straight from flops.

module btn_debounce #(
  parameter int N_BTN    = 5,
  parameter int CNT_W    = 20,
  parameter int DB_LIMIT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  input  logic             clr_we,
  input  logic [N_BTN-1:0] clr_mask,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_event
);

  // Terminal count: the DB_LIMIT-th consecutive differing sample flips the
  // level, so the counter never needs to hold DB_LIMIT itself and cannot wrap.
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DB_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchroniser stages; sync_s2 is the first sample safe to use in logic.
  logic [N_BTN-1:0] sync_s1;
  logic [N_BTN-1:0] sync_s2;

  // Per-button stability counters, current and next.
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  // Next-state values for the registered outputs.
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] event_d;
  logic [N_BTN-1:0] clr_bits;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      // NOTE: non-blocking so sync_s2 takes the previous sync_s1; a blocking
      // assignment would collapse both stages into a single flop.
      sync_s1 <= btn_i;
      sync_s2 <= sync_s1;
    end
  end

  // Stability counter and level acceptance: agreement restarts the count,
  // a full run of disagreement adopts the synchronised sample.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    level_d = btn_level;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync_s2[i] != btn_level[i]) begin
        if (cnt_q[i] == CNT_TOP) begin
          level_d[i] = sync_s2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Press pulse and sticky flag: a press on the same edge as a clear wins so
  // that no event is ever lost; an all-zero mask or idle strobe clears nothing.
  always_comb begin
    press_d  = level_d & ~btn_level;
    clr_bits = {N_BTN{clr_we}} & clr_mask;
    event_d  = press_d | (btn_event & ~clr_bits);
  end

  // Counter state; cleared by reset so a mid-count reset starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this array is a bank of ordinary flops, not a RAM, so it is
      // reset explicitly; a stale count surviving reset would shorten the
      // first debounce after reset release.
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Registered outputs: filtered level, press pulse and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= '0;
      btn_press <= '0;
      btn_event <= '0;
    end else begin
      btn_level <= level_d;
      btn_press <= press_d;
      btn_event <= event_d;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed scenarios plus randomized bounce traffic for
// btn_debounce, configured with DB_LIMIT = 4 and N_BTN = 5.

module tb_btn_debounce;

  localparam int N  = 5;
  localparam int CW = 3;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_i = '0;
  logic         clr_we = 1'b0;
  logic [N-1:0] clr_mask = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_event;

  int n_checks = 0;
  int n_pass   = 0;
  bit sb_en    = 1'b0;

  btn_debounce #(.N_BTN(N), .CNT_W(CW), .DB_LIMIT(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn_i),
    .clr_we   (clr_we),
    .clr_mask (clr_mask),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_event(btn_event)
  );

  always #5 clk = ~clk;

  // Reference model: a button's level follows the pins once the last DB
  // synchronised samples (pin values two edges stale) all disagree with it.
  bit [N-1:0] hq[$];
  bit [N-1:0] m_level, m_press, m_event;
  int         m_pulses;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level = '0;
      m_press = '0;
      m_event = '0;
      hq.delete();
      for (int j = 0; j <= DB; j++) hq.push_back('0);
    end else begin
      bit [N-1:0] nl;
      bit         all_diff;
      nl = m_level;
      for (int i = 0; i < N; i++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DB; j++)
          if (hq[j][i] == m_level[i]) all_diff = 1'b0;
        if (all_diff) nl[i] = ~m_level[i];
      end
      m_press = nl & ~m_level;
      m_event = m_press | (m_event & ~(clr_we ? clr_mask : '0));
      m_level = nl;
      for (int i = 0; i < N; i++) if (m_press[i]) m_pulses++;
      hq.push_front(btn_i);
      void'(hq.pop_back());
    end
  end

  // Scoreboard: compare every output against the model away from the edge.
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      n_checks++;
      if ({btn_level, btn_press, btn_event} !== {m_level, m_press, m_event})
        $display("FAIL scoreboard t=%0t got lvl=%b prs=%b evt=%b want lvl=%b prs=%b evt=%b",
                 $time, btn_level, btn_press, btn_event, m_level, m_press, m_event);
      else
        n_pass++;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; btn_i = '0; clr_we = 1'b0; clr_mask = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts edges (sampled 1 after each) until btn_level[b] equals v; n = -1
  // when the bound expires. Also counts press pulses seen on button b.
  task automatic edges_until_level(input int b, input logic v,
                                   output int n, output int pulses);
    n = -1;
    pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (btn_press[b] === 1'b1) pulses++;
      if (btn_level[b] === v) begin
        n = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n, p;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({btn_level, btn_press, btn_event} !== '0)
      $display("FAIL reset_state got %b want 0", {btn_level, btn_press, btn_event});
    else n_pass++;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    sb_en = 1'b1;
    @(negedge clk);
    btn_i = 5'b00001;
    edges_until_level(0, 1'b1, n, p);
    n_checks++;
    if (btn_event !== 5'b00001) $display("FAIL first_press_event got %b want 00001", btn_event);
    else n_pass++;
    @(negedge clk);
    btn_i = 5'b00000;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    btn_i = 5'b00001;
    #1;
    n_checks++;
    if ({btn_level, btn_press, btn_event} !== '0)
      $display("FAIL async_reset got %b want 0", {btn_level, btn_press, btn_event});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    edges_until_level(0, 1'b1, n, p);
    n_checks++;
    if (n !== 6) $display("FAIL reset_held_latency got %0d want 6", n);
    else n_pass++;
    n_checks++;
    if (p !== 1) $display("FAIL reset_held_pulses got %0d want 1", p);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (btn_press[0] !== 1'b0) $display("FAIL reset_held_pulse_end got %b want 0", btn_press[0]);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    int n, p, extra;
    apply_reset();
    btn_i = 5'b00100;
    edges_until_level(2, 1'b1, n, p);
    n_checks++;
    if (n !== 6) $display("FAIL press_latency got %0d want 6", n);
    else n_pass++;
    n_checks++;
    if (btn_press !== 5'b00100) $display("FAIL press_pulse got %b want 00100", btn_press);
    else n_pass++;
    n_checks++;
    if (btn_event !== 5'b00100) $display("FAIL press_event got %b want 00100", btn_event);
    else n_pass++;
    extra = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (btn_press[2] === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL press_hold_pulses got %0d want 0", extra);
    else n_pass++;
    @(negedge clk);
    btn_i = 5'b00000;
    edges_until_level(2, 1'b0, n, p);
    n_checks++;
    if (n !== 6) $display("FAIL release_latency got %0d want 6", n);
    else n_pass++;
    n_checks++;
    if (p !== 0) $display("FAIL release_pulses got %0d want 0", p);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int n, p, extra;
    logic chg;
    apply_reset();
    chg = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      btn_i[1] = (k % 2 == 0);
      repeat (2) begin
        @(posedge clk); #1;
        chg = chg | btn_level[1] | btn_press[1];
      end
    end
    n_checks++;
    if (chg !== 1'b0) $display("FAIL bounce_stable got %b want 0", chg);
    else n_pass++;
    @(negedge clk);
    btn_i[1] = 1'b1;
    edges_until_level(1, 1'b1, n, p);
    n_checks++;
    if (n !== 6) $display("FAIL bounce_latency got %0d want 6", n);
    else n_pass++;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (btn_press[1] === 1'b1) extra++;
    end
    n_checks++;
    if (p + extra !== 1) $display("FAIL bounce_pulses got %0d want 1", p + extra);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [N-1:0] seen;
    apply_reset();
    btn_i = 5'b01000;
    seen = '0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      seen = seen | btn_level | btn_press | btn_event;
      if (e == 2) begin
        @(negedge clk);
        btn_i = 5'b00000;
      end
    end
    n_checks++;
    if (seen !== '0) $display("FAIL glitch_reject got %b want 00000", seen);
    else n_pass++;
  endtask

  task automatic test_clear();
    apply_reset();
    btn_i = 5'b10011;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (btn_event !== 5'b10011) $display("FAIL clear_setup got %b want 10011", btn_event);
    else n_pass++;
    @(negedge clk);
    btn_i = 5'b00000;
    repeat (8) @(posedge clk);
    @(negedge clk);
    clr_we = 1'b0; clr_mask = 5'b11111;
    @(posedge clk); #1;
    n_checks++;
    if (btn_event !== 5'b10011) $display("FAIL clear_idle_mask got %b want 10011", btn_event);
    else n_pass++;
    @(negedge clk);
    clr_we = 1'b1; clr_mask = 5'b00000;
    @(posedge clk); #1;
    n_checks++;
    if (btn_event !== 5'b10011) $display("FAIL clear_zero_mask got %b want 10011", btn_event);
    else n_pass++;
    @(negedge clk);
    clr_mask = 5'b00011;
    @(posedge clk); #1;
    n_checks++;
    if (btn_event !== 5'b10000) $display("FAIL clear_masked got %b want 10000", btn_event);
    else n_pass++;
    @(negedge clk);
    clr_we = 1'b0; clr_mask = '0;
    btn_i = 5'b10000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    clr_we = 1'b1; clr_mask = 5'b10000;
    @(posedge clk); #1;
    n_checks++;
    if ({btn_press[4], btn_event} !== {1'b1, 5'b10000})
      $display("FAIL clear_vs_press got prs=%b evt=%b want prs=1 evt=10000", btn_press[4], btn_event);
    else n_pass++;
    @(negedge clk);
    clr_we = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (btn_event !== 5'b10000) $display("FAIL clear_hold got %b want 10000", btn_event);
    else n_pass++;
    @(negedge clk);
    clr_we = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (btn_event !== 5'b00000) $display("FAIL clear_bit4 got %b want 00000", btn_event);
    else n_pass++;
    @(negedge clk);
    clr_we = 1'b0; clr_mask = '0; btn_i = '0;
  endtask

  task automatic test_simultaneous();
    int n, p;
    apply_reset();
    btn_i = 5'b11111;
    edges_until_level(0, 1'b1, n, p);
    n_checks++;
    if (n !== 6) $display("FAIL simul_latency got %0d want 6", n);
    else n_pass++;
    n_checks++;
    if ({btn_level, btn_press, btn_event} !== {3{5'b11111}})
      $display("FAIL simul_outputs got lvl=%b prs=%b evt=%b want all 11111", btn_level, btn_press, btn_event);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (btn_press !== 5'b00000) $display("FAIL simul_pulse_end got %b want 00000", btn_press);
    else n_pass++;
  endtask

  task automatic test_random();
    int rl[N];
    int dut_pulses;
    apply_reset();
    m_pulses = 0;
    dut_pulses = 0;
    for (int i = 0; i < N; i++) rl[i] = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rl[i] == 0) begin
          btn_i[i] = ~btn_i[i];
          rl[i] = $urandom_range(1, 9);
        end
        rl[i]--;
      end
      clr_we   = ($urandom_range(0, 7) == 0);
      clr_mask = N'($urandom);
      if (c == 400) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      @(posedge clk); #1;
      if (!rst) for (int i = 0; i < N; i++) if (btn_press[i] === 1'b1) dut_pulses++;
    end
    n_checks++;
    if (dut_pulses !== m_pulses) $display("FAIL random_pulse_count got %0d want %0d", dut_pulses, m_pulses);
    else n_pass++;
    @(negedge clk);
    btn_i = '0; clr_we = 1'b0; clr_mask = '0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_clear();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
